// File: rtl/seq_detect_param.sv
// Parametrised Moore serial sequence detector with KMP fall-back, a run-time
// overlap mode, a bit-valid qualifier and a saturating match counter.
module seq_detect_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             ovlp,
    input  logic             cnt_clr,
    output logic             detect,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int KW = $clog2(PAT_LEN + 1);
    localparam int NS = 2 ** KW;

    generate
        if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
            $error("seq_detect_param: PAT_LEN must be within 2..16");
        end
    endgenerate

    // Pattern bit i counted from the first bit received.
    function automatic logic pat_bit(input int i);
        logic [PAT_LEN-1:0] p;
        p = PATTERN >> (PAT_LEN - 1 - i);
        return p[0];
    endfunction

    // Longest prefix matched after appending bit b to a kp-bit matched prefix.
    function automatic int kmp_next(input int kp, input logic b);
        int   best;
        int   t;
        logic ok;
        logic sb;
        best = 0;
        for (int j = kp + 1; j >= 1; j--) begin
            if (best == 0) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    t  = kp + 1 - j + i;
                    sb = (t == kp) ? b : pat_bit(t);
                    if (sb != pat_bit(i)) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    // Longest proper prefix of the pattern that is also a suffix.
    function automatic int fail_len(input int n);
        int   best;
        logic ok;
        best = 0;
        for (int j = n - 1; j >= 1; j--) begin
            if (best == 0) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    if (pat_bit(n - j + i) != pat_bit(i)) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    localparam int            F_LEN   = fail_len(PAT_LEN);
    localparam logic [KW-1:0] K_FULL  = KW'(PAT_LEN);
    localparam logic [KW-1:0] K_FAIL  = KW'(F_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [KW-1:0] nxt0_tab [NS];
    logic [KW-1:0] nxt1_tab [NS];

    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_tab
            if (gi < PAT_LEN) begin : g_live
                assign nxt0_tab[gi] = KW'(kmp_next(gi, 1'b0));
                assign nxt1_tab[gi] = KW'(kmp_next(gi, 1'b1));
            end else begin : g_dead
                assign nxt0_tab[gi] = '0;
                assign nxt1_tab[gi] = '0;
            end
        end
    endgenerate

    logic [KW-1:0]    k_q, k_d, k_prime;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q   <= '0;
            cnt_q <= '0;
        end else begin
            k_q   <= k_d;
            cnt_q <= cnt_d;
        end
    end

    // A completed match restarts from the border (overlap) or from empty.
    always_comb begin
        k_prime = k_q;
        k_d     = k_q;
        if (k_q == K_FULL) begin
            k_prime = ovlp ? K_FAIL : '0;
        end
        if (k_q > K_FULL) begin
            k_d = '0;
        end else if (din_valid) begin
            k_d = din ? nxt1_tab[k_prime] : nxt0_tab[k_prime];
        end
    end

    always_comb begin
        hit   = din_valid && (k_d == K_FULL);
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        detect    = (k_q == K_FULL);
        match_cnt = cnt_q;
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default instance plus a 2-bit counter
// instance sharing the same stimulus.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       ovlp = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       detect1, detect2;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .ovlp(ovlp), .cnt_clr(cnt_clr), .detect(detect1), .match_cnt(cnt1)
    );

    seq_detect_param #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .ovlp(ovlp), .cnt_clr(cnt_clr), .detect(detect2), .match_cnt(cnt2)
    );

    task automatic step(input logic d, input logic v);
        din       = d;
        din_valid = v;
        @(posedge clk);
        #1;
        $display("t=%0t rst=%b din=%b vld=%b ovlp=%b clr=%b -> k=%0d detect=%b cnt=%0d cnt2=%0d",
                 $time, reset, d, v, ovlp, cnt_clr, dut.k_q, detect1, cnt1, cnt2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        reset = 1'b0;
        checks++;
        if (dut.k_q !== 3'd0) begin
            errors++; $display("FAIL reset_k: got %0d expected 0", dut.k_q);
        end
        checks++;
        if (detect1 !== 1'b0) begin
            errors++; $display("FAIL reset_detect: got %b expected 0", detect1);
        end
        checks++;
        if (cnt1 !== 8'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt1);
        end
    endtask

    task automatic test_stream(input logic mode);
        logic [7:0] bits;
        logic [7:0] exp_det;
        int         exp_cnt [8];
        do_reset();
        ovlp = mode;
        bits = 8'b1010_1010;
        if (mode) begin
            exp_det = 8'b0001_0101;
            exp_cnt = '{0, 0, 0, 1, 1, 2, 2, 3};
        end else begin
            exp_det = 8'b0001_0001;
            exp_cnt = '{0, 0, 0, 1, 1, 1, 1, 2};
        end
        for (int i = 0; i < 8; i++) begin
            step(bits[7-i], 1'b1);
            checks++;
            if (detect1 !== exp_det[7-i]) begin
                errors++;
                $display("FAIL stream_detect ovlp=%b bit%0d: got %b expected %b",
                         mode, i + 1, detect1, exp_det[7-i]);
            end
            checks++;
            if (cnt1 !== 8'(exp_cnt[i])) begin
                errors++;
                $display("FAIL stream_cnt ovlp=%b bit%0d: got %0d expected %0d",
                         mode, i + 1, cnt1, exp_cnt[i]);
            end
        end
        ovlp = 1'b0;
    endtask

    task automatic test_fallback();
        logic [4:0] bits;
        int         exp_k [5];
        do_reset();
        bits  = 5'b11010;
        exp_k = '{1, 1, 2, 3, 4};
        for (int i = 0; i < 5; i++) begin
            step(bits[4-i], 1'b1);
            checks++;
            if (dut.k_q !== 3'(exp_k[i])) begin
                errors++;
                $display("FAIL fallback_k bit%0d: got %0d expected %0d", i + 1, dut.k_q, exp_k[i]);
            end
            checks++;
            if (detect1 !== (i == 4)) begin
                errors++;
                $display("FAIL fallback_detect bit%0d: got %b expected %b", i + 1, detect1, (i == 4));
            end
        end
    endtask

    task automatic test_gaps();
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(i[0], 1'b0);
            checks++;
            if (dut.k_q !== 3'd3 || detect1 !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold cycle%0d: got k=%0d detect=%b expected k=3 detect=0",
                         i, dut.k_q, detect1);
            end
        end
        step(1'b0, 1'b1);
        checks++;
        if (detect1 !== 1'b1 || cnt1 !== 8'd1) begin
            errors++;
            $display("FAIL gap_match: got detect=%b cnt=%0d expected detect=1 cnt=1", detect1, cnt1);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (detect1 !== 1'b1 || cnt1 !== 8'd1) begin
                errors++;
                $display("FAIL gap_detect_hold cycle%0d: got detect=%b cnt=%0d expected detect=1 cnt=1",
                         i, detect1, cnt1);
            end
        end
    endtask

    task automatic test_saturate();
        int exp_c;
        do_reset();
        ovlp  = 1'b1;
        exp_c = 0;
        for (int i = 0; i < 12; i++) begin
            step(~i[0], 1'b1);
            if (i >= 3 && i[0]) begin
                exp_c = (exp_c < 3) ? exp_c + 1 : 3;
                checks++;
                if (cnt2 !== 2'(exp_c) || detect2 !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_cnt bit%0d: got cnt=%0d detect=%b expected cnt=%0d detect=1",
                             i + 1, cnt2, detect2, exp_c);
                end
            end
        end
        step(1'b1, 1'b1);
        cnt_clr = 1'b1;
        step(1'b0, 1'b1);
        cnt_clr = 1'b0;
        checks++;
        if (cnt2 !== 2'd0 || detect2 !== 1'b1) begin
            errors++;
            $display("FAIL sat_clr: got cnt=%0d detect=%b expected cnt=0 detect=1", cnt2, detect2);
        end
        ovlp = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        reset = 1'b1;
        step(1'b0, 1'b1);
        reset = 1'b0;
        checks++;
        if (dut.k_q !== 3'd0 || detect1 !== 1'b0 || cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_pattern: got k=%0d detect=%b cnt=%0d expected 0 0 0",
                     dut.k_q, detect1, cnt1);
        end
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        if (detect1 !== 1'b1 || cnt1 !== 8'd1) begin
            errors++;
            $display("FAIL reset_mid_redetect: got detect=%b cnt=%0d expected 1 1", detect1, cnt1);
        end
        reset = 1'b1;
        step(1'b1, 1'b1);
        reset = 1'b0;
        checks++;
        if (dut.k_q !== 3'd0 || detect1 !== 1'b0 || cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_detect: got k=%0d detect=%b cnt=%0d expected 0 0 0",
                     dut.k_q, detect1, cnt1);
        end
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if (detect1 !== 1'b0) begin
            errors++; $display("FAIL reset_after_early: got detect=%b expected 0", detect1);
        end
        step(1'b0, 1'b1);
        checks++;
        if (detect1 !== 1'b1 || cnt1 !== 8'd1) begin
            errors++;
            $display("FAIL reset_after_detect: got detect=%b cnt=%0d expected 1 1", detect1, cnt1);
        end
    endtask

    initial begin
        test_reset();
        test_stream(1'b0);
        test_stream(1'b1);
        test_fallback();
        test_gaps();
        test_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
